// File: rtl/int_sched.sv
// Interrupt scheduler for the where-to-go branch unit: edge-detects three irq
// lines, picks the highest permitted level and keeps one return slot per level.
module int_sched #(
  parameter int NLVL = 3,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NLVL-1:0] irq,
  input  logic            int_en,
  input  logic            stall,
  input  logic            jint_taken,
  input  logic            eret_taken,
  input  logic [PC_W-1:0] ret_pc,
  output logic [2:0]      ints,
  output logic [PC_W-1:0] epc,
  output logic [NLVL-1:0] pending,
  output logic [NLVL-1:0] in_service,
  output logic            spurious
);

  logic [NLVL-1:0] irq_q;
  logic [PC_W-1:0] slot [NLVL];
  logic [NLVL-1:0] rise;
  logic [1:0]      svc_lvl;
  logic [1:0]      req_lvl;
  logic            grant;
  logic            jint_v;
  logic            eret_v;
  logic            do_acc;
  logic            do_ret;
  logic            spur_next;
  logic [NLVL-1:0] acc_mask;
  logic [NLVL-1:0] ret_mask;

  function automatic logic [1:0] top_level(input logic [2:0] v);
    if (v[2]) begin
      return 2'd3;
    end else if (v[1]) begin
      return 2'd2;
    end else if (v[0]) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

  function automatic logic [2:0] level_mask(input logic [1:0] l);
    case (l)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign rise    = irq & ~irq_q;
  assign svc_lvl = top_level(in_service);
  assign req_lvl = top_level(pending);
  assign grant   = int_en && (req_lvl > svc_lvl);
  assign jint_v  = jint_taken && !stall;
  assign eret_v  = eret_taken && !stall;

  // A simultaneous ERET always wins over JINT; the losing accept is reported as spurious.
  always_comb begin
    do_ret    = eret_v && (svc_lvl != 2'd0);
    do_acc    = jint_v && !eret_v && grant;
    spur_next = (jint_v && (!grant || eret_v)) || (eret_v && (svc_lvl == 2'd0));
    if (do_acc) begin
      acc_mask = level_mask(req_lvl);
    end else begin
      acc_mask = 3'b000;
    end
    if (do_ret) begin
      ret_mask = level_mask(svc_lvl);
    end else begin
      ret_mask = 3'b000;
    end
  end

  // Requested code and visible return address, both decoded from registers.
  always_comb begin
    if (grant) begin
      ints = {1'b0, req_lvl};
    end else begin
      ints = 3'd0;
    end
    case (svc_lvl)
      2'd1:    epc = slot[0];
      2'd2:    epc = slot[1];
      2'd3:    epc = slot[2];
      default: epc = {PC_W{1'b0}};
    endcase
  end

  // State update; a new edge on a level being accepted keeps its pending bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q      <= 3'b000;
      pending    <= 3'b000;
      in_service <= 3'b000;
      spurious   <= 1'b0;
      for (int i = 0; i < NLVL; i++) begin
        slot[i] <= {PC_W{1'b0}};
      end
    end else begin
      irq_q      <= irq;
      pending    <= (pending & ~acc_mask) | rise;
      in_service <= (in_service | acc_mask) & ~ret_mask;
      spurious   <= spur_next;
      for (int i = 0; i < NLVL; i++) begin
        if (acc_mask[i]) begin
          slot[i] <= ret_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_int_sched.sv
// Bench for int_sched: directed scenarios with fixed expectations, then random
// traffic against a level-stack reference model.
module tb_int_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  irq = 3'b000;
  logic        int_en = 1'b0;
  logic        stall = 1'b0;
  logic        jint_taken = 1'b0;
  logic        eret_taken = 1'b0;
  logic [31:0] ret_pc = 32'd0;
  logic [2:0]  ints;
  logic [31:0] epc;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic        spurious;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: pending flags plus a stack of accepted (level, pc) pairs.
  bit [2:0]    m_pend;
  bit [2:0]    m_prev;
  bit          m_spur;
  int          m_lvl[$];
  logic [31:0] m_pc[$];

  int_sched #(.NLVL(3), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .irq(irq), .int_en(int_en), .stall(stall),
    .jint_taken(jint_taken), .eret_taken(eret_taken), .ret_pc(ret_pc),
    .ints(ints), .epc(epc), .pending(pending), .in_service(in_service),
    .spurious(spurious)
  );

  always #5 clk = ~clk;

  function automatic int m_svc();
    return (m_lvl.size() > 0) ? m_lvl[m_lvl.size()-1] : 0;
  endfunction

  function automatic int m_ints();
    int p = 0;
    for (int i = 0; i < 3; i++) if (m_pend[i]) p = i + 1;
    return (int_en && p > m_svc()) ? p : 0;
  endfunction

  function automatic logic [31:0] m_epc();
    return (m_pc.size() > 0) ? m_pc[m_pc.size()-1] : 32'd0;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    bit [2:0] rise;
    int s, g;
    bit jv, ev;
    if (rst) begin
      m_pend = 3'b000; m_prev = 3'b000; m_spur = 1'b0;
      m_lvl.delete(); m_pc.delete();
    end else begin
      rise = irq & ~m_prev;
      m_prev = irq;
      s = m_svc();
      g = m_ints();
      jv = jint_taken && !stall;
      ev = eret_taken && !stall;
      m_spur = (jv && (g == 0 || ev)) || (ev && s == 0);
      if (ev) begin
        if (s != 0) begin
          void'(m_lvl.pop_back());
          void'(m_pc.pop_back());
        end
      end else if (jv && g != 0) begin
        m_pend[g-1] = 1'b0;
        m_lvl.push_back(g);
        m_pc.push_back(ret_pc);
      end
      m_pend = m_pend | rise;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    irq = 3'b000; int_en = 1'b0; stall = 1'b0;
    jint_taken = 1'b0; eret_taken = 1'b0; ret_pc = 32'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ints !== 3'd0) begin n_fail++; $display("FAIL reset_ints got %h want 0", ints); end
    n_checks++; if (epc !== 32'd0) begin n_fail++; $display("FAIL reset_epc got %h want 0", epc); end
    n_checks++; if (pending !== 3'b000 || in_service !== 3'b000 || spurious !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got pend=%b isv=%b spur=%b want 0", pending, in_service, spurious); end
  endtask

  task automatic test_single();
    do_reset();
    int_en = 1'b1; irq = 3'b001; tick();
    n_checks++; if (ints !== 3'd1) begin n_fail++; $display("FAIL single_req got %0d want 1", ints); end
    jint_taken = 1'b1; ret_pc = 32'h0000_0040; tick(); jint_taken = 1'b0;
    n_checks++; if (in_service !== 3'b001 || pending !== 3'b000 || epc !== 32'h40 || ints !== 3'd0) begin
      n_fail++; $display("FAIL single_acc got isv=%b pend=%b epc=%h ints=%0d want 001 000 40 0", in_service, pending, epc, ints); end
    eret_taken = 1'b1; tick(); eret_taken = 1'b0;
    n_checks++; if (in_service !== 3'b000 || epc !== 32'd0) begin
      n_fail++; $display("FAIL single_ret got isv=%b epc=%h want 000 0", in_service, epc); end
  endtask

  task automatic test_nesting();
    do_reset();
    int_en = 1'b1; irq = 3'b001; tick();
    jint_taken = 1'b1; ret_pc = 32'h40; tick(); jint_taken = 1'b0;
    irq = 3'b101; tick();
    n_checks++; if (ints !== 3'd3) begin n_fail++; $display("FAIL nest_req got %0d want 3", ints); end
    jint_taken = 1'b1; ret_pc = 32'h100; tick(); jint_taken = 1'b0;
    n_checks++; if (in_service !== 3'b101 || epc !== 32'h100) begin
      n_fail++; $display("FAIL nest_acc got isv=%b epc=%h want 101 100", in_service, epc); end
    eret_taken = 1'b1; tick();
    n_checks++; if (epc !== 32'h40) begin n_fail++; $display("FAIL nest_ret1 got %h want 40", epc); end
    tick(); eret_taken = 1'b0;
    n_checks++; if (epc !== 32'd0 || in_service !== 3'b000) begin
      n_fail++; $display("FAIL nest_ret2 got epc=%h isv=%b want 0 000", epc, in_service); end
  endtask

  task automatic test_no_preempt();
    do_reset();
    int_en = 1'b1; irq = 3'b100; tick();
    jint_taken = 1'b1; ret_pc = 32'h200; tick(); jint_taken = 1'b0;
    irq = 3'b101; tick();
    n_checks++; if (pending !== 3'b001 || ints !== 3'd0) begin
      n_fail++; $display("FAIL nopre_hold got pend=%b ints=%0d want 001 0", pending, ints); end
    eret_taken = 1'b1; tick(); eret_taken = 1'b0;
    n_checks++; if (ints !== 3'd1) begin n_fail++; $display("FAIL nopre_after got %0d want 1", ints); end
  endtask

  task automatic test_mask_stall();
    do_reset();
    irq = 3'b010; tick();
    n_checks++; if (pending !== 3'b010 || ints !== 3'd0) begin
      n_fail++; $display("FAIL mask_off got pend=%b ints=%0d want 010 0", pending, ints); end
    int_en = 1'b1; #1;
    n_checks++; if (ints !== 3'd2) begin n_fail++; $display("FAIL mask_on got %0d want 2", ints); end
    jint_taken = 1'b1; stall = 1'b1; ret_pc = 32'h80; tick();
    n_checks++; if (in_service !== 3'b000 || pending !== 3'b010 || spurious !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold got isv=%b pend=%b spur=%b want 000 010 0", in_service, pending, spurious); end
    stall = 1'b0; tick(); jint_taken = 1'b0;
    n_checks++; if (in_service !== 3'b010 || pending !== 3'b000 || epc !== 32'h80) begin
      n_fail++; $display("FAIL stall_acc got isv=%b pend=%b epc=%h want 010 000 80", in_service, pending, epc); end
  endtask

  task automatic test_spurious();
    do_reset();
    int_en = 1'b1; jint_taken = 1'b1; tick(); jint_taken = 1'b0;
    n_checks++; if (spurious !== 1'b1 || pending !== 3'b000 || in_service !== 3'b000) begin
      n_fail++; $display("FAIL spur_jint got spur=%b pend=%b isv=%b want 1 000 000", spurious, pending, in_service); end
    tick();
    n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL spur_pulse got %b want 0", spurious); end
    eret_taken = 1'b1; tick(); eret_taken = 1'b0;
    n_checks++; if (spurious !== 1'b1) begin n_fail++; $display("FAIL spur_eret got %b want 1", spurious); end
    irq = 3'b001; tick();
    jint_taken = 1'b1; ret_pc = 32'h40; tick(); jint_taken = 1'b0;
    irq = 3'b101; tick();
    jint_taken = 1'b1; eret_taken = 1'b1; ret_pc = 32'h300; tick();
    jint_taken = 1'b0; eret_taken = 1'b0;
    n_checks++; if (in_service !== 3'b000 || pending !== 3'b100 || spurious !== 1'b1 || ints !== 3'd3) begin
      n_fail++; $display("FAIL collide got isv=%b pend=%b spur=%b ints=%0d want 000 100 1 3", in_service, pending, spurious, ints); end
  endtask

  task automatic test_edge();
    do_reset();
    int_en = 1'b1; irq = 3'b010; tick();
    n_checks++; if (pending !== 3'b010) begin n_fail++; $display("FAIL hold_first got %b want 010", pending); end
    jint_taken = 1'b1; tick(); jint_taken = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (pending !== 3'b000 || in_service !== 3'b010) begin
      n_fail++; $display("FAIL hold_once got pend=%b isv=%b want 000 010", pending, in_service); end
    do_reset();
    int_en = 1'b1; irq = 3'b001; tick();
    irq = 3'b000; tick();
    irq = 3'b001; jint_taken = 1'b1; ret_pc = 32'h44; tick(); jint_taken = 1'b0;
    n_checks++; if (pending !== 3'b001 || in_service !== 3'b001) begin
      n_fail++; $display("FAIL set_wins got pend=%b isv=%b want 001 001", pending, in_service); end
    rst = 1'b1; tick();
    n_checks++; if ({ints, epc, pending, in_service, spurious} !== 42'd0) begin
      n_fail++; $display("FAIL mid_reset got ints=%0d epc=%h pend=%b isv=%b spur=%b want all 0", ints, epc, pending, in_service, spurious); end
    rst = 1'b0; tick();
    n_checks++; if (pending !== 3'b001) begin n_fail++; $display("FAIL held_reset got %b want 001", pending); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) irq = irq ^ 3'($urandom_range(0, 7));
      int_en     = ($urandom_range(0, 5) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      jint_taken = ($urandom_range(0, 9) < 3);
      eret_taken = ($urandom_range(0, 9) < 2);
      ret_pc     = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      rst        = ($urandom_range(0, 149) == 0);
      tick();
      n_checks++;
      if (ints !== 3'(m_ints()) || epc !== m_epc() || pending !== m_pend || spurious !== m_spur) begin
        n_fail++;
        $display("FAIL rand_cyc%0d got ints=%0d epc=%h pend=%b spur=%b want %0d %h %b %b",
                 n, ints, epc, pending, spurious, m_ints(), m_epc(), m_pend, m_spur);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_nesting();
    test_no_preempt();
    test_mask_stall();
    test_spurious();
    test_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
